// File: rtl/index_sort_if.sv
// index_sort_if: bundles the sort job request, the unsorted input vector and
// the sorted result/status outputs of index_sort.
//
// Handshake: a job is requested by a rising edge on start (level high after
// having been low at the previous clock edge). busy is high while the job
// runs. done is high while the sorted result is held on data_out/index_out.
// data_out/index_out are valid only while done is high. There is no
// backpressure; the sorter ignores start rises while busy.
interface index_sort_if #(
  parameter int SIZE = 4,
  parameter int NW   = 8,
  parameter int IW   = 4
);
  logic                     start;
  logic [SIZE-1:0][NW-1:0]  data_in;
  logic [SIZE-1:0][NW-1:0]  data_out;
  logic [SIZE-1:0][IW-1:0]  index_out;
  logic                     busy;
  logic                     done;
  logic [1:0]               dbg_state;

  // Requester side: drives jobs, observes results.
  modport master (
    output start, data_in,
    input  data_out, index_out, busy, done, dbg_state
  );

  // Sorter side.
  modport slave (
    input  start, data_in,
    output data_out, index_out, busy, done, dbg_state
  );
endinterface

// File: rtl/index_sort.sv
// index_sort: odd-even transposition sorter that carries each element's
// original position alongside it, so a later stage can undo the permutation.
// One transposition phase per clock; SIZE phases per job (ascending, stable).
// Optional feature macro: SORT_EARLY_EXIT_EN -- finish as soon as an even
// phase and its following odd phase both made no swap.
package index_sort_pkg;
  localparam int NETWORK_WIDTH = 8;
  localparam int INDEX_WIDTH   = 4;
endpackage

module index_sort
  import index_sort_pkg::*;
#(
  parameter int SIZE = 4
) (
  input  logic         clk,
  input  logic         reset,
  index_sort_if.slave  bus
);

  localparam int PW = (SIZE > 1) ? $clog2(SIZE) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SORT = 2'd1,
    DONE = 2'd2
  } state_t;

  // Every original position must be representable in an index.
  generate
    if ((2 ** INDEX_WIDTH) < SIZE) begin : g_index_width_check
      $error("index_sort: INDEX_WIDTH too narrow for SIZE");
    end
  endgenerate

  state_t                              state_q, state_d;
  logic [SIZE-1:0][NETWORK_WIDTH-1:0]  data_q, data_d, swap_data;
  logic [SIZE-1:0][INDEX_WIDTH-1:0]    index_q, index_d, swap_index;
  logic [PW-1:0]                       phase_q, phase_d;
  logic                                start_q;
  logic                                busy_q, busy_d;
  logic                                done_q, done_d;
  logic                                start_rise;
  logic                                any_swap;
  logic                                last_phase;
  logic                                exit_now;
`ifdef SORT_EARLY_EXIT_EN
  logic                                even_swap_q, even_swap_d;
`endif

  assign start_rise = bus.start & ~start_q;
  assign last_phase = (phase_q == PW'(SIZE - 1));

`ifdef SORT_EARLY_EXIT_EN
  // Stop at the end of an odd phase when it and the preceding even phase
  // were both swap-free: the buffer is then already ordered.
  assign exit_now = last_phase | (phase_q[0] & ~even_swap_q & ~any_swap);
`else
  assign exit_now = last_phase;
`endif

  // One transposition phase: disjoint pairs starting at the phase parity,
  // element and index move together, equal values stay put (stability).
  always_comb begin
    swap_data  = data_q;
    swap_index = index_q;
    any_swap   = 1'b0;
    for (int k = 0; k < SIZE - 1; k++) begin
      if (k[0] == phase_q[0]) begin
        if (data_q[k] > data_q[k+1]) begin
          swap_data[k]    = data_q[k+1];
          swap_data[k+1]  = data_q[k];
          swap_index[k]   = index_q[k+1];
          swap_index[k+1] = index_q[k];
          any_swap        = 1'b1;
        end
      end
    end
  end

  // Job sequencing: load on a start rise, sort phase by phase, then hold.
  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    index_d = index_q;
    phase_d = phase_q;
    busy_d  = busy_q;
    done_d  = done_q;
`ifdef SORT_EARLY_EXIT_EN
    even_swap_d = even_swap_q;
`endif
    case (state_q)
      IDLE, DONE: begin
        if (start_rise) begin
          data_d = bus.data_in;
          for (int k = 0; k < SIZE; k++) begin
            index_d[k] = INDEX_WIDTH'(k);
          end
          phase_d = '0;
          busy_d  = 1'b1;
          done_d  = 1'b0;
          state_d = SORT;
        end
      end
      SORT: begin
        data_d  = swap_data;
        index_d = swap_index;
`ifdef SORT_EARLY_EXIT_EN
        if (!phase_q[0]) begin
          even_swap_d = any_swap;
        end
`endif
        if (exit_now) begin
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = DONE;
        end else begin
          phase_d = phase_q + PW'(1);
        end
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
        done_d  = 1'b0;
      end
    endcase
  end

  // State registers; reset clears everything without waiting for a clock.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      data_q  <= '0;
      index_q <= '0;
      phase_q <= '0;
      start_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef SORT_EARLY_EXIT_EN
      even_swap_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      index_q <= index_d;
      phase_q <= phase_d;
      start_q <= bus.start;
      busy_q  <= busy_d;
      done_q  <= done_d;
`ifdef SORT_EARLY_EXIT_EN
      even_swap_q <= even_swap_d;
`endif
    end
  end

  assign bus.data_out  = data_q;
  assign bus.index_out = index_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.dbg_state = state_q;

endmodule
